apb_slave_m: RTL and testbench

APB_SLAVE_M -- requirements
Module: apb_slave_m

---
 rtl/apb_slave_m.sv | 139 +++++++++++++
 tb/tb_apb_slave_m.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/apb_slave_m.sv
// APB slave with a word-addressed internal memory, configurable wait states
// and error reporting for out-of-range addresses and access phases with no
// preceding setup phase.
module apb_slave_m #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic                  pslver,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic             ph_setup;
    logic             ph_access;
    logic             in_xfer;
    logic             done;
    logic             idle_err;
    logic             addr_err;
    logic             mem_we;
    logic [CMP_W-1:0] addr_ext;
    logic [IDX_W-1:0] idx;

    // Bus phase decode; the access phase of a transfer is the cycle(s) that
    // follow a registered setup, so both SETUP and ACCESS states count as
    // "inside a transfer" when penable is high.
    assign ph_setup  = psel & ~penable;
    assign ph_access = psel & penable;
    assign in_xfer   = (state_q == SETUP) || (state_q == ACCESS);

    assign addr_ext  = CMP_W'(addr_q);
    assign addr_err  = addr_ext >= CMP_W'(DEPTH);
    assign idx       = addr_q[IDX_W-1:0];

    assign done      = in_xfer & ph_access & (wait_q == CNT_W'(WAIT_STATES));
    // An access with no setup completes immediately with an error and
    // touches nothing.
    assign idle_err  = (state_q == IDLE) & ph_access;
    assign pready    = done | idle_err;
    assign pslver    = idle_err | (done & addr_err);
    assign mem_we    = done & write_q & ~addr_err;
    assign prdata    = (done & ~write_q & ~addr_err) ? mem_q[idx] : '0;

    // Next-state and wait-counter logic; the counter only advances while a
    // transfer is stretched and is cleared in every other case.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            IDLE: begin
                if (ph_setup) state_d = SETUP;
            end
            SETUP: begin
                if (ph_access) begin
                    if (done) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACCESS;
                        wait_d  = wait_q + CNT_W'(1);
                    end
                end else if (!psel) begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (ph_access) begin
                    if (done) begin
                        state_d = IDLE;
                    end else begin
                        wait_d  = wait_q + CNT_W'(1);
                    end
                end else if (ph_setup) begin
                    // penable dropped with psel held: restart as a new setup
                    state_d = SETUP;
                end else begin
                    // psel dropped before completion: abandon the transfer
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, wait counter and setup-phase capture of address/direction/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (ph_setup) begin
                addr_q  <= paddr;
                wdata_q <= pwdata;
                write_q <= pwrite;
            end
        end
    end

    // Memory array: cleared on reset, written on a successful write completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_m.sv
// Directed bench for apb_slave_m: one instance without wait states and one
// with two wait states, sharing the bus except for their select lines.
module tb_apb_slave_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel0, psel2, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready0, pslver0, pready2, pslver2;
    logic [31:0] prdata0, prdata2;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_slave_m #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready0), .pslver(pslver0), .prdata(prdata0)
    );

    apb_slave_m #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .psel(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready2), .pslver(pslver2), .prdata(prdata2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of bus inputs just after a rising edge, then return at
    // the following falling edge where the combinational outputs are checked.
    task automatic bus(input logic r, input logic s0, input logic s2, input logic en,
                       input logic wr, input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r; psel0 = s0; psel2 = s2; penable = en; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;

        // Reset and idle bus
        bus(1, 0, 0, 0, 0, 8'h00, 32'h0);
        chk("rst_pready", {31'b0, pready0}, 32'h0);
        bus(0, 0, 0, 0, 0, 8'h00, 32'h0);
        chk("idle_pready", {31'b0, pready0}, 32'h0);
        chk("idle_pslver", {31'b0, pslver0}, 32'h0);
        chk("idle_prdata", prdata0, 32'h0);

        // Write 0x04 <= DEADBEEF, then back-to-back read of 0x04
        bus(0, 1, 0, 0, 1, 8'h04, 32'hDEADBEEF);
        chk("wr_setup_pready", {31'b0, pready0}, 32'h0);
        bus(0, 1, 0, 1, 1, 8'h04, 32'hDEADBEEF);
        chk("wr_acc_pready", {31'b0, pready0}, 32'h1);
        chk("wr_acc_pslver", {31'b0, pslver0}, 32'h0);
        bus(0, 1, 0, 0, 0, 8'h04, 32'h0);
        chk("rd_setup_pready", {31'b0, pready0}, 32'h0);
        chk("rd_setup_prdata", prdata0, 32'h0);
        bus(0, 1, 0, 1, 0, 8'h04, 32'h0);
        chk("rd04_pready", {31'b0, pready0}, 32'h1);
        chk("rd04_prdata", prdata0, 32'hDEADBEEF);
        chk("rd04_pslver", {31'b0, pslver0}, 32'h0);

        // Read of a never-written address
        bus(0, 1, 0, 0, 0, 8'h10, 32'h0);
        bus(0, 1, 0, 1, 0, 8'h10, 32'h0);
        chk("rd10_pready", {31'b0, pready0}, 32'h1);
        chk("rd10_prdata", prdata0, 32'h0);
        chk("rd10_pslver", {31'b0, pslver0}, 32'h0);

        // Out-of-range write, then read of 0x00 must not see it
        bus(0, 1, 0, 0, 1, 8'h80, 32'hCAFEF00D);
        bus(0, 1, 0, 1, 1, 8'h80, 32'hCAFEF00D);
        chk("wr80_pready", {31'b0, pready0}, 32'h1);
        chk("wr80_pslver", {31'b0, pslver0}, 32'h1);
        bus(0, 1, 0, 0, 0, 8'h00, 32'h0);
        bus(0, 1, 0, 1, 0, 8'h00, 32'h0);
        chk("rd00_prdata", prdata0, 32'h0);
        chk("rd00_pslver", {31'b0, pslver0}, 32'h0);

        // Out-of-range read returns zero with an error
        bus(0, 1, 0, 0, 0, 8'hC4, 32'h0);
        bus(0, 1, 0, 1, 0, 8'hC4, 32'h0);
        chk("rdC4_pslver", {31'b0, pslver0}, 32'h1);
        chk("rdC4_prdata", prdata0, 32'h0);

        // Access with no setup: immediate error, no data, FSM remains idle
        bus(0, 0, 0, 0, 0, 8'h04, 32'h0);
        bus(0, 1, 0, 1, 0, 8'h04, 32'h0);
        chk("noset_pready", {31'b0, pready0}, 32'h1);
        chk("noset_pslver", {31'b0, pslver0}, 32'h1);
        chk("noset_prdata", prdata0, 32'h0);
        bus(0, 1, 0, 1, 0, 8'h04, 32'h0);
        chk("noset2_pslver", {31'b0, pslver0}, 32'h1);
        bus(0, 0, 0, 1, 0, 8'h04, 32'h0);
        chk("pen_nosel_pready", {31'b0, pready0}, 32'h0);

        // Reset during the access cycle of a write to 0x08
        bus(0, 1, 0, 0, 1, 8'h08, 32'h12345678);
        bus(1, 1, 0, 1, 1, 8'h08, 32'h12345678);
        bus(0, 0, 0, 0, 0, 8'h00, 32'h0);
        chk("postrst_pready", {31'b0, pready0}, 32'h0);
        bus(0, 1, 0, 0, 0, 8'h08, 32'h0);
        bus(0, 1, 0, 1, 0, 8'h08, 32'h0);
        chk("rd08_pready", {31'b0, pready0}, 32'h1);
        chk("rd08_prdata", prdata0, 32'h0);
        bus(0, 1, 0, 0, 0, 8'h04, 32'h0);
        bus(0, 1, 0, 1, 0, 8'h04, 32'h0);
        chk("rd04_cleared", prdata0, 32'h0);
        bus(0, 0, 0, 0, 0, 8'h00, 32'h0);

        // Two wait states: write 0x04 then read it back
        bus(0, 0, 1, 0, 1, 8'h04, 32'hA5A5A5A5);
        chk("ws_wr_setup", {31'b0, pready2}, 32'h0);
        bus(0, 0, 1, 1, 1, 8'h04, 32'hA5A5A5A5);
        chk("ws_wr_acc1", {31'b0, pready2}, 32'h0);
        bus(0, 0, 1, 1, 1, 8'h04, 32'hA5A5A5A5);
        chk("ws_wr_acc2", {31'b0, pready2}, 32'h0);
        bus(0, 0, 1, 1, 1, 8'h04, 32'hA5A5A5A5);
        chk("ws_wr_acc3", {31'b0, pready2}, 32'h1);
        bus(0, 0, 1, 0, 0, 8'h04, 32'h0);
        bus(0, 0, 1, 1, 0, 8'h04, 32'h0);
        chk("ws_rd_acc1", {31'b0, pready2}, 32'h0);
        chk("ws_rd_acc1_data", prdata2, 32'h0);
        bus(0, 0, 1, 1, 0, 8'h04, 32'h0);
        chk("ws_rd_acc2", {31'b0, pready2}, 32'h0);
        bus(0, 0, 1, 1, 0, 8'h04, 32'h0);
        chk("ws_rd_acc3", {31'b0, pready2}, 32'h1);
        chk("ws_rd_data", prdata2, 32'hA5A5A5A5);
        chk("ws_rd_pslver", {31'b0, pslver2}, 32'h0);

        // Two wait states: psel dropped mid-access aborts the write to 0x05
        bus(0, 0, 1, 0, 1, 8'h05, 32'h11111111);
        bus(0, 0, 1, 1, 1, 8'h05, 32'h11111111);
        bus(0, 0, 0, 1, 1, 8'h05, 32'h11111111);
        chk("ws_abort_pready", {31'b0, pready2}, 32'h0);
        bus(0, 0, 1, 0, 0, 8'h05, 32'h0);
        bus(0, 0, 1, 1, 0, 8'h05, 32'h0);
        bus(0, 0, 1, 1, 0, 8'h05, 32'h0);
        bus(0, 0, 1, 1, 0, 8'h05, 32'h0);
        chk("ws_abort_rd_pready", {31'b0, pready2}, 32'h1);
        chk("ws_abort_rd_data", prdata2, 32'h0);
        bus(0, 0, 0, 0, 0, 8'h00, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
